req_ack_sequencer: RTL
======================

REQ_ACK_SEQUENCER -- requirements
Module: req_ack_sequencer

Interface
REQ-001 Parameter MAX_DLY, default 5, maximum request-to-c latency in cycles (legal 1..7).
REQ-002 Parameter CNT_W, default 8, width of the done/abort/drop event counters.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 ce  input  1  enable; must stay high for a whole sequence.
REQ-006 a  input  1  request level; its rising edge starts a sequence.
REQ-007 dly  input  3  requested latency from the a rising edge to c, in cycles.
REQ-008 c  output  1  grant pulse, one cycle wide.
REQ-009 b  output  1  done pulse, one cycle wide, in the cycle after c.
REQ-010 busy  output  1  high while a sequence is in progress.
REQ-011 abort  output  1  one-cycle pulse when a sequence is killed because ce went low.
REQ-012 done_cnt  output  CNT_W  count of completed sequences; saturates at all-ones.
REQ-013 abort_cnt  output  CNT_W  count of aborted sequences; saturates at all-ones.
REQ-014 drop_cnt  output  CNT_W  count of ignored a rising edges; saturates at all-ones.

Function
REQ-015 a SHALL be registered into a_q each cycle; a rising edge is a==1 && a_q==0 sampled at posedge.
REQ-016 The FSM SHALL have four states: IDLE, WAIT, C_PH, B_PH.
REQ-017 IDLE: a rising edge with ce==1 SHALL load the latency counter and move to WAIT, or to C_PH when the effective latency is 1.
REQ-018 IDLE: a rising edge with ce==0 SHALL be ignored and drop_cnt SHALL increment.
REQ-019 Effective latency D: dly==0 -> 1; dly>MAX_DLY -> MAX_DLY; otherwise dly.
REQ-020 WAIT SHALL decrement the counter each cycle and move to C_PH so that c is high in exactly the cycle starting D edges after the detecting edge.
REQ-021 C_PH: c==1 for one cycle, then move to B_PH.
REQ-022 B_PH: b==1 for one cycle, then move to IDLE and increment done_cnt.
REQ-023 c and b SHALL be registered (decoded from state), glitch-free, and never high in the same cycle.
REQ-024 busy SHALL be 1 in WAIT, C_PH and B_PH, and 0 in IDLE.
REQ-025 Any cycle with ce==0 while busy SHALL force the next state to IDLE.
REQ-026 That next edge SHALL pulse abort for one cycle with c=b=0, and increment abort_cnt.
REQ-027 An ce==0 abort in B_PH SHALL take priority over completion: no done_cnt increment.
REQ-028 An a rising edge while busy SHALL be ignored (no restart) and drop_cnt SHALL increment.
REQ-029 The IDLE cycle following B_PH or abort SHALL accept a new rising edge (back-to-back sequences allowed).
REQ-030 dly SHALL be sampled only on the starting edge; later changes to dly SHALL have no effect on an in-flight sequence.
REQ-031 All counters SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-032 rst_n low SHALL immediately (asynchronously) force state=IDLE, a_q=0, c=b=busy=abort=0, and all counters=0.
REQ-033 Reset asserted mid-sequence SHALL discard the sequence silently: no abort pulse, no counter change.
REQ-034 After rst_n deasserts, an a held high through reset SHALL NOT count as a rising edge (a_q resynchronises).

Verification
REQ-035 Base case: ce=1, dly=3, a rises at edge k -> c high during cycle k+3, b high during cycle k+4, done_cnt=1, busy low from k+5.
REQ-036 Clamping: dly=0 -> c at k+1 and b at k+2; dly=7 with MAX_DLY=5 -> c at k+5 and b at k+6.
REQ-037 Abort: ce=1, dly=4, ce falls at k+2 -> abort pulse at k+3, c and b never asserted, abort_cnt=1, done_cnt unchanged.
REQ-038 Overlap: a second rising edge of a at k+2 during a dly=5 sequence -> original c at k+5 and b at k+6, drop_cnt=1.
REQ-039 Reset mid-WAIT: rst_n low at k+1 -> all outputs 0 at once, counters 0, no c, b or abort afterwards.
REQ-040 Bind the property "rising a implies c rises within 1..MAX_DLY cycles then b rises next cycle, with ce held throughout"; it SHALL pass for all legal-ce runs and fail only on aborted runs.

Source files
------------

// File: rtl/req_ack_sequencer.sv
// Request/acknowledge sequencer: an a rising edge launches c after a clamped latency, then b.
// Latency: c appears D cycles after the detecting edge, b one cycle later; ce low aborts at the next edge.
// Backpressure: none; rising edges while busy or with ce low are dropped and counted.
module req_ack_sequencer #(
   parameter int MAX_DLY = 5,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic             a,
   input  logic [2:0]       dly,
   output logic             c,
   output logic             b,
   output logic             busy,
   output logic             abort,
   output logic [CNT_W-1:0] done_cnt,
   output logic [CNT_W-1:0] abort_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   typedef enum logic [1:0] {IDLE, WAIT, C_PH, B_PH} state_t;

   localparam logic [2:0] MAX_D = 3'(MAX_DLY);

   state_t     state;
   logic [2:0] cnt;
   logic       a_q;
   logic       armed;
   logic [2:0] eff_dly;
   logic       rise;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (&x) ? x : x + 1'b1;
   endfunction

   always_comb begin
      eff_dly = dly;
      if (dly == 3'd0)
         eff_dly = 3'd1;
      else if (dly > MAX_D)
         eff_dly = MAX_D;
   end

   // armed blocks a level held through reset from looking like a fresh edge
   assign rise = armed && a && !a_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         a_q       <= 1'b0;
         armed     <= 1'b0;
         c         <= 1'b0;
         b         <= 1'b0;
         busy      <= 1'b0;
         abort     <= 1'b0;
         done_cnt  <= '0;
         abort_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         a_q   <= a;
         armed <= 1'b1;
         c     <= 1'b0;
         b     <= 1'b0;
         abort <= 1'b0;

         if (rise && (state != IDLE || !ce))
            drop_cnt <= sat_inc(drop_cnt);

         if (state == IDLE) begin
            busy <= 1'b0;
            if (rise && ce) begin
               busy  <= 1'b1;
               cnt   <= eff_dly - 3'd1;
               state <= (eff_dly == 3'd1) ? C_PH : WAIT;
            end
         end else if (!ce) begin
            // abort wins over every in-flight phase, including completion
            state     <= IDLE;
            busy      <= 1'b0;
            abort     <= 1'b1;
            abort_cnt <= sat_inc(abort_cnt);
         end else begin
            busy <= 1'b1;
            case (state)
               WAIT: begin
                  if (cnt == 3'd1)
                     state <= C_PH;
                  else
                     cnt <= cnt - 3'd1;
               end
               C_PH: begin
                  c     <= 1'b1;
                  state <= B_PH;
               end
               B_PH: begin
                  b        <= 1'b1;
                  state    <= IDLE;
                  done_cnt <= sat_inc(done_cnt);
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
